// File: rtl/debounce_filter_if.sv
// Signal bundle between a raw switch/button source and its debouncer.
// The master drives the raw level; the slave (the debouncer) returns the
// clean level and a busy flag.
interface debounce_filter_if;
    // Raw asynchronous switch/button level
    logic in;
    // Debounced, registered level
    logic db_out;
    // High while a candidate level change is being timed
    logic busy;

    modport master (
        output in,
        input  db_out,
        input  busy
    );

    modport slave (
        input  in,
        output db_out,
        output busy
    );
endinterface

// File: rtl/debounce_filter.sv
// Switch/button debouncer with built-in metastability synchronizer.
// A new level is accepted only once the synchronized input has held it for
// STABLE_CNT+1 consecutive samples; any reversal while timing throws the
// candidate away and restarts from zero. db_out feeds a downstream edge
// detector, so it must never glitch on a rejected bounce.
module debounce_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = 500000
) (
    input  logic              clk,
    input  logic              reset,
    debounce_filter_if.slave  bus
);

    localparam int unsigned CntW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CNT - 1);

    typedef enum logic [1:0] {
        StIdleLow,
        StWaitHigh,
        StIdleHigh,
        StWaitLow
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   in_s;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   busy_q, busy_d;

    // Synchronizer chain: bring the raw level into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in};
        end
    end

    assign in_s = sync_q[SYNC_STAGES-1];

    // Debounce state, stability counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdleLow;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: time candidate levels, commit or reject them
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;

        unique case (state_q)
            StIdleLow: begin
                if (in_s) begin
                    state_d = StWaitHigh;
                    cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!in_s) begin
                    // Bounce: drop the candidate, no partial credit kept
                    state_d = StIdleLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdleHigh;
                    db_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdleHigh: begin
                if (!in_s) begin
                    state_d = StWaitLow;
                    cnt_d   = '0;
                end
            end
            StWaitLow: begin
                if (in_s) begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdleLow;
                    db_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdleLow;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase

        // Registered busy mirrors "next state is a timing state"
        busy_d = (state_d == StWaitHigh) || (state_d == StWaitLow);
    end

    assign bus.db_out = db_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter (SYNC_STAGES=2, STABLE_CNT=8).
// Reference model: a history of sampled inputs plus a run-length rule
// (flip the clean level after STABLE_CNT+1 consecutive differing samples).
module tb_debounce_filter;

    localparam int unsigned Sync   = 2;
    localparam int unsigned Stable = 8;
    localparam int          Lat    = Sync + Stable;

    logic clk;
    logic reset;

    debounce_filter_if bus();

    debounce_filter #(
        .SYNC_STAGES (Sync),
        .STABLE_CNT  (Stable)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit hist[$];
    int run;
    bit m_db;
    bit m_busy;
    int m_rises;

    // Observed-side bookkeeping (downstream edge detector stand-in)
    bit db_prev;
    int ped_cnt;
    bit saw_busy;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        run     = 0;
        m_db    = 1'b0;
        m_busy  = 1'b0;
        db_prev = 1'b0;
    endtask

    task automatic model_step(input bit in_now);
        int k;
        bit s;
        hist.push_back(in_now);
        k = hist.size() - 1;
        s = (k >= Sync) ? hist[k - Sync] : 1'b0;
        if (s != m_db) run++;
        else run = 0;
        if (run == Stable + 1) begin
            m_db = s;
            run  = 0;
            if (s) m_rises++;
        end
        m_busy = (run != 0);
    endtask

    // One rising edge: advance model, then compare away from the edge
    task automatic tick();
        bit in_now;
        @(posedge clk);
        in_now = bus.in;
        if (reset) model_step(in_now);
        else model_clear();
        #1;
        check_eq("db_out", int'(bus.db_out), int'(m_db));
        check_eq("busy", int'(bus.busy), int'(m_busy));
        if (bus.busy) saw_busy = 1'b1;
        if (bus.db_out && !db_prev) ped_cnt++;
        db_prev = bus.db_out;
    endtask

    task automatic run_level(input bit lvl, input int cycles);
        bus.in = lvl;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Apply a step and report the edge indices where busy and db_out respond
    task automatic step_measure(input bit lvl, output int n_db, output int n_busy);
        n_db   = -1;
        n_busy = -1;
        bus.in = lvl;
        for (int i = 0; i < 4 * Lat; i++) begin
            tick();
            if (n_busy < 0 && bus.busy) n_busy = i;
            if (bus.db_out == lvl) begin
                n_db = i;
                break;
            end
        end
    endtask

    initial begin
        int n_db;
        int n_busy;
        int rises_before;
        bit lvl;

        m_rises  = 0;
        ped_cnt  = 0;
        saw_busy = 1'b0;
        model_clear();

        // 1: reset low with in=1 clears outputs before any clock edge
        reset  = 1'b0;
        bus.in = 1'b1;
        #1;
        check_eq("rst_async_db", int'(bus.db_out), 0);
        check_eq("rst_async_busy", int'(bus.busy), 0);
        for (int i = 0; i < 5; i++) tick();

        // Release with in high: no special power-up case
        @(negedge clk);
        reset = 1'b1;
        step_measure(1'b1, n_db, n_busy);
        check_eq("pwrup_rise_edge", n_db, Lat);
        check_eq("pwrup_busy_edge", n_busy, Sync);
        run_level(1'b1, 3);

        // 2: falling then rising clean steps
        step_measure(1'b0, n_db, n_busy);
        check_eq("fall_edge", n_db, Lat);
        check_eq("fall_busy_edge", n_busy, Sync);
        check_eq("fall_busy_clr", int'(bus.busy), 0);
        run_level(1'b0, 3);
        step_measure(1'b1, n_db, n_busy);
        check_eq("rise_edge", n_db, Lat);
        check_eq("rise_busy_edge", n_busy, Sync);
        check_eq("rise_busy_clr", int'(bus.busy), 0);
        run_level(1'b1, 3);
        step_measure(1'b0, n_db, n_busy);
        run_level(1'b0, 4);

        // 3: bounce pattern never commits
        rises_before = ped_cnt;
        saw_busy     = 1'b0;
        run_level(1'b1, 3);
        run_level(1'b0, 2);
        run_level(1'b1, 5);
        run_level(1'b0, 12);
        check_eq("bounce_no_rise", ped_cnt - rises_before, 0);
        check_eq("bounce_busy_seen", int'(saw_busy), 1);
        check_eq("bounce_idle_busy", int'(bus.busy), 0);

        // 4: exactly STABLE_CNT samples rejected, STABLE_CNT+1 accepted
        rises_before = ped_cnt;
        run_level(1'b1, Stable);
        run_level(1'b0, 12);
        check_eq("bound8_reject", ped_cnt - rises_before, 0);
        run_level(1'b1, Stable + 1);
        run_level(1'b0, Sync);
        check_eq("bound9_accept", int'(bus.db_out), 1);
        check_eq("bound9_pulse", ped_cnt - rises_before, 1);
        run_level(1'b0, 12);

        // 5: reset in the middle of WAIT_HIGH (cnt reaches 5 after edge 7)
        run_level(1'b1, 8);
        check_eq("pre_rst_busy", int'(bus.busy), 1);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_eq("midrst_db", int'(bus.db_out), 0);
        check_eq("midrst_busy", int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b1;
        step_measure(1'b1, n_db, n_busy);
        check_eq("postrst_rise_edge", n_db, Lat);
        run_level(1'b1, 4);
        step_measure(1'b0, n_db, n_busy);
        run_level(1'b0, 4);

        // 6: random press/release/bounce traffic, one pulse per accepted rise
        lvl = 1'b1;
        for (int seg = 0; seg < 60; seg++) begin
            run_level(lvl, int'($urandom_range(1, 14)));
            lvl = ~lvl;
        end
        run_level(1'b0, 2 * Lat);
        check_eq("ped_pulse_count", ped_cnt, m_rises);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
